// File: rtl/pe_row_sequencer_if.sv
// Window/filter, PE and result handshake bundle for pe_row_sequencer.
// The bias signal exists only when PE_SEQ_BIAS_EN is defined.
interface pe_row_sequencer_if #(
  parameter int WIN_SIZE  = 3,
  parameter int IN_WIDTH  = 5,
  parameter int W_WIDTH   = 8,
  parameter int ACC_WIDTH = 15
);
  logic                                   win_valid;
  logic                                   win_ready;
  logic [WIN_SIZE*WIN_SIZE*IN_WIDTH-1:0]  win_data;
  logic [WIN_SIZE*WIN_SIZE*W_WIDTH-1:0]   win_filter;
`ifdef PE_SEQ_BIAS_EN
  logic [ACC_WIDTH-1:0]                   bias;
`endif
  logic                                   pe_start;
  logic [WIN_SIZE*IN_WIDTH-1:0]           pe_in_data;
  logic [WIN_SIZE*W_WIDTH-1:0]            pe_in_filter;
  logic [ACC_WIDTH-1:0]                   pe_in_partial;
  logic [ACC_WIDTH-1:0]                   pe_out_data;
  logic                                   pe_finished;
  logic                                   res_valid;
  logic                                   res_ready;
  logic [ACC_WIDTH-1:0]                   res_data;

  modport master (
`ifdef PE_SEQ_BIAS_EN
    input  bias,
`endif
    input  win_valid, win_data, win_filter, pe_out_data, pe_finished, res_ready,
    output win_ready, pe_start, pe_in_data, pe_in_filter, pe_in_partial,
    output res_valid, res_data
  );

  modport slave (
`ifdef PE_SEQ_BIAS_EN
    output bias,
`endif
    output win_valid, win_data, win_filter, pe_out_data, pe_finished, res_ready,
    input  win_ready, pe_start, pe_in_data, pe_in_filter, pe_in_partial,
    input  res_valid, res_data
  );
endinterface

// File: rtl/pe_row_sequencer.sv
// Drives one external 3-tap PE once per window row, chaining partial sums.
// Optional PE_SEQ_BIAS_EN: row 0 partial comes from a bias captured with the window.
module pe_row_sequencer #(
  parameter int WIN_SIZE  = 3,
  parameter int IN_WIDTH  = 5,
  parameter int W_WIDTH   = 8,
  parameter int ACC_WIDTH = 15
) (
  input logic              clk,
  input logic              rst,
  pe_row_sequencer_if.master bus
);
  localparam int ROW_IN = WIN_SIZE * IN_WIDTH;
  localparam int ROW_W  = WIN_SIZE * W_WIDTH;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_REL, S_OUT} state_t;

  state_t                       state_q, state_d;
  logic [1:0]                   row_q, row_d;
  logic [ACC_WIDTH-1:0]         partial_q, partial_d;
  logic [ACC_WIDTH-1:0]         res_data_q, res_data_d;
  logic                         res_valid_q, res_valid_d;
  logic                         pe_start_q, pe_start_d;
  logic [WIN_SIZE*ROW_IN-1:0]   win_q, win_d;
  logic [WIN_SIZE*ROW_W-1:0]    filt_q, filt_d;
  logic                         win_hs;

  // Never offer a window while a stale pe_finished is still up.
  assign bus.win_ready = (state_q == S_IDLE) && !bus.pe_finished && !rst;
  assign win_hs        = bus.win_valid && bus.win_ready;

  always_comb begin
    state_d     = state_q;
    row_d       = row_q;
    partial_d   = partial_q;
    res_data_d  = res_data_q;
    res_valid_d = res_valid_q;
    pe_start_d  = pe_start_q;
    win_d       = win_q;
    filt_d      = filt_q;
    unique case (state_q)
      S_IDLE: begin
        if (win_hs) begin
          win_d      = bus.win_data;
          filt_d     = bus.win_filter;
          row_d      = '0;
`ifdef PE_SEQ_BIAS_EN
          partial_d  = bus.bias;
`else
          partial_d  = '0;
`endif
          pe_start_d = 1'b1;
          state_d    = S_RUN;
        end
      end
      S_RUN: begin
        if (bus.pe_finished) begin
          partial_d  = bus.pe_out_data;
          pe_start_d = 1'b0;
          state_d    = S_REL;
        end
      end
      S_REL: begin
        if (!bus.pe_finished) begin
          if (row_q == 2'd2) begin
            res_data_d  = partial_q;
            res_valid_d = 1'b1;
            state_d     = S_OUT;
          end else begin
            row_d      = row_q + 2'd1;
            pe_start_d = 1'b1;
            state_d    = S_RUN;
          end
        end
      end
      S_OUT: begin
        if (bus.res_ready) begin
          res_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      row_q       <= '0;
      partial_q   <= '0;
      res_data_q  <= '0;
      res_valid_q <= 1'b0;
      pe_start_q  <= 1'b0;
      win_q       <= '0;
      filt_q      <= '0;
    end else begin
      state_q     <= state_d;
      row_q       <= row_d;
      partial_q   <= partial_d;
      res_data_q  <= res_data_d;
      res_valid_q <= res_valid_d;
      pe_start_q  <= pe_start_d;
      win_q       <= win_d;
      filt_q      <= filt_d;
    end
  end

  // Row select is a mux of registers held constant across the whole PE transaction.
  always_comb begin
    bus.pe_in_data   = win_q[0 +: ROW_IN];
    bus.pe_in_filter = filt_q[0 +: ROW_W];
    case (row_q)
      2'd1: begin
        bus.pe_in_data   = win_q[ROW_IN +: ROW_IN];
        bus.pe_in_filter = filt_q[ROW_W +: ROW_W];
      end
      2'd2: begin
        bus.pe_in_data   = win_q[2*ROW_IN +: ROW_IN];
        bus.pe_in_filter = filt_q[2*ROW_W +: ROW_W];
      end
      default: ;
    endcase
  end

  assign bus.pe_start      = pe_start_q;
  assign bus.pe_in_partial = partial_q;
  assign bus.res_valid     = res_valid_q;
  assign bus.res_data      = res_data_q;
endmodule

// File: tb/tb_pe_row_sequencer.sv
// Scoreboard bench for pe_row_sequencer with a behavioural 3-tap PE responder.
module tb_pe_row_sequencer;
  localparam int IW = 5;
  localparam int WW = 8;
  localparam int AW = 15;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  pe_row_sequencer_if #(.WIN_SIZE(3), .IN_WIDTH(IW), .W_WIDTH(WW), .ACC_WIDTH(AW)) bus ();

  pe_row_sequencer #(.WIN_SIZE(3), .IN_WIDTH(IW), .W_WIDTH(WW), .ACC_WIDTH(AW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_cmp = 0;
  int n_err = 0;
  int pe_lat = 1;
  int starts_seen = 0;
  logic start_prev = 1'b0;
  logic [AW-1:0] exp_res[$];
  logic [AW-1:0] exp_part[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [AW-1:0] pe_calc();
    logic [AW-1:0] acc;
    logic [IW-1:0] d;
    logic [WW-1:0] w;
    logic [3*IW-1:0] dv;
    logic [3*WW-1:0] fv;
    dv  = bus.pe_in_data;
    fv  = bus.pe_in_filter;
    acc = bus.pe_in_partial;
    for (int i = 0; i < 3; i++) begin
      d   = dv[i*IW +: IW];
      w   = fv[i*WW +: WW];
      acc = acc + AW'(d * w);
    end
    return acc;
  endfunction

  // External PE: finish pe_lat cycles after start, hold finished until start drops.
  initial begin
    int cnt;
    cnt = 0;
    bus.pe_finished = 1'b0;
    bus.pe_out_data = '0;
    forever begin
      @(posedge clk); #1;
      if (rst) begin
        bus.pe_finished = 1'b0;
        cnt = 0;
      end else if (!bus.pe_finished && bus.pe_start) begin
        if (cnt >= pe_lat) begin
          bus.pe_out_data = pe_calc();
          bus.pe_finished = 1'b1;
          cnt = 0;
        end else begin
          cnt++;
        end
      end else if (bus.pe_finished && !bus.pe_start) begin
        bus.pe_finished = 1'b0;
      end else begin
        cnt = 0;
      end
    end
  end

  always @(negedge clk) begin
    if (rst === 1'b0 && bus.res_valid && bus.res_ready) begin
      if (exp_res.size() == 0) begin
        n_cmp++; n_err++;
        $display("FAIL res_unexpected: got %0d expected none", bus.res_data);
      end else begin
        check("res_data", 32'(bus.res_data), 32'(exp_res.pop_front()));
      end
    end
  end

  always @(negedge clk) begin
    if (bus.pe_start && !start_prev) begin
      starts_seen++;
      if (exp_part.size() == 0) begin
        n_cmp++; n_err++;
        $display("FAIL pe_start_unexpected: got partial %0d expected no start", bus.pe_in_partial);
      end else begin
        check("pe_in_partial", 32'(bus.pe_in_partial), 32'(exp_part.pop_front()));
      end
    end
    start_prev = bus.pe_start;
  end

  function automatic logic [9*IW-1:0] fill_d(input logic [IW-1:0] v);
    logic [9*IW-1:0] r;
    for (int i = 0; i < 9; i++) r[i*IW +: IW] = v;
    return r;
  endfunction

  function automatic logic [9*WW-1:0] fill_w(input logic [WW-1:0] v);
    logic [9*WW-1:0] r;
    for (int i = 0; i < 9; i++) r[i*WW +: WW] = v;
    return r;
  endfunction

  function automatic logic [9*IW-1:0] seq_d();
    logic [9*IW-1:0] r;
    for (int i = 0; i < 9; i++) r[i*IW +: IW] = IW'(i + 1);
    return r;
  endfunction

  task automatic expect_win(input logic [AW-1:0] res, input logic [AW-1:0] p0,
                            input logic [AW-1:0] p1, input logic [AW-1:0] p2);
    exp_res.push_back(res);
    exp_part.push_back(p0);
    exp_part.push_back(p1);
    exp_part.push_back(p2);
  endtask

  task automatic drive_window(input logic [9*IW-1:0] d, input logic [9*WW-1:0] f,
                              input logic [AW-1:0] b);
    bus.win_data   = d;
    bus.win_filter = f;
`ifdef PE_SEQ_BIAS_EN
    bus.bias       = b;
`else
    if (b != 0) $display("note: bias ignored in this build");
`endif
    bus.win_valid  = 1'b1;
  endtask

  task automatic wait_accept(output int cycles);
    cycles = 0;
    while (1) begin
      @(negedge clk);
      cycles++;
      if (bus.win_ready) break;
      if (cycles > 300) begin
        n_cmp++; n_err++;
        $display("FAIL accept_timeout: got no win_ready expected within 300 cycles");
        break;
      end
    end
    @(posedge clk); #1;
    bus.win_valid = 1'b0;
  endtask

  task automatic send_window(input logic [9*IW-1:0] d, input logic [9*WW-1:0] f,
                             input logic [AW-1:0] b);
    int c;
    drive_window(d, f, b);
    wait_accept(c);
  endtask

  task automatic wait_drain();
    int c;
    c = 0;
    while (exp_res.size() != 0 && c < 500) begin
      @(posedge clk); #1;
      c++;
    end
    check("drain_done", 32'(exp_res.size()), 32'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    int base;
    int c;
    rst = 1'b1;
    bus.win_valid = 1'b0;
    bus.win_data = '0;
    bus.win_filter = '0;
    bus.res_ready = 1'b1;
`ifdef PE_SEQ_BIAS_EN
    bus.bias = '0;
`endif
    repeat (2) @(posedge clk);
    #1;
    check("rst_pe_start", 32'(bus.pe_start), 32'd0);
    check("rst_res_valid", 32'(bus.res_valid), 32'd0);
    check("rst_res_data", 32'(bus.res_data), 32'd0);
    check("rst_win_ready", 32'(bus.win_ready), 32'd0);
    check("rst_partial", 32'(bus.pe_in_partial), 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    check("idle_win_ready", 32'(bus.win_ready), 32'd1);

    // All ones -> 9, partials 0,3,6, three starts
    pe_lat = 1;
    base = starts_seen;
    expect_win(15'd9, 15'd0, 15'd3, 15'd6);
    send_window(fill_d(5'd1), fill_w(8'd1), '0);
    wait_drain();
    check("start_count", 32'(starts_seen - base), 32'd3);

    // 1..9 with filter 2 -> 90, partials 0,12,42
    pe_lat = 0;
    expect_win(15'd90, 15'd0, 15'd12, 15'd42);
    send_window(seq_d(), fill_w(8'd2), '0);
    wait_drain();

    // Max values -> 71145 mod 32768 = 5609; partials 0,23715,14662
    pe_lat = 2;
    expect_win(15'd5609, 15'd0, 15'd23715, 15'd14662);
    send_window(fill_d(5'd31), fill_w(8'd255), '0);
    wait_drain();

    // Downstream stall for 20 cycles with a second window already waiting
    pe_lat = 1;
    bus.res_ready = 1'b0;
    expect_win(15'd9, 15'd0, 15'd3, 15'd6);
    send_window(fill_d(5'd1), fill_w(8'd1), '0);
    c = 0;
    while (!bus.res_valid && c < 300) begin
      @(posedge clk); #1;
      c++;
    end
    check("stall_res_valid_seen", 32'(bus.res_valid), 32'd1);
    expect_win(15'd90, 15'd0, 15'd12, 15'd42);
    drive_window(seq_d(), fill_w(8'd2), '0);
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      check("stall_res_valid", 32'(bus.res_valid), 32'd1);
      check("stall_res_data", 32'(bus.res_data), 32'd9);
      check("stall_win_ready", 32'(bus.win_ready), 32'd0);
    end
    bus.res_ready = 1'b1;
    wait_accept(c);
    check("b2b_accept_prompt", 32'(c <= 2), 32'd1);
    wait_drain();

    // Reset during row 1 run; aborted window only produces two starts
    pe_lat = 3;
    exp_part.push_back(15'd0);
    exp_part.push_back(15'd12);
    base = starts_seen;
    send_window(seq_d(), fill_w(8'd2), '0);
    c = 0;
    while (starts_seen < base + 2 && c < 300) begin
      @(posedge clk); #1;
      c++;
    end
    check("abort_row1_started", 32'(starts_seen - base), 32'd2);
    check("abort_pe_start_high", 32'(bus.pe_start), 32'd1);
    rst = 1'b1;
    #1;
    check("abort_pe_start", 32'(bus.pe_start), 32'd0);
    check("abort_res_valid", 32'(bus.res_valid), 32'd0);
    check("abort_win_ready", 32'(bus.win_ready), 32'd0);
    check("abort_partial", 32'(bus.pe_in_partial), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    pe_lat = 1;
    expect_win(15'd9, 15'd0, 15'd3, 15'd6);
    send_window(fill_d(5'd1), fill_w(8'd1), '0);
    wait_drain();

`ifdef PE_SEQ_BIAS_EN
    // Bias 100 seeds row 0 -> 109
    expect_win(15'd109, 15'd100, 15'd103, 15'd106);
    send_window(fill_d(5'd1), fill_w(8'd1), 15'd100);
    wait_drain();
`endif

    repeat (3) @(posedge clk);
    #1;
    check("partials_consumed", 32'(exp_part.size()), 32'd0);
    check("end_res_valid", 32'(bus.res_valid), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/pe_row_sequencer.md
Name: pe_row_sequencer

Overview:
Initiator side of the PE start/finished handshake. It accepts a 3x3 input window and a 3x3 filter from upstream over valid/ready. It then drives a single external 3-tap PE three times, once per row, chaining each row's result into the next row's partial-sum input. The final 3x3 dot product goes downstream over valid/ready. It sits between the window/line-buffer logic and a PE instance.

Parameters:
WIN_SIZE, 3, taps per row and rows per window; fixed at 3
IN_WIDTH, 5, activation element width (unsigned)
W_WIDTH, 8, weight element width (unsigned)
ACC_WIDTH, 15, partial/result width; arithmetic wraps mod 2^ACC_WIDTH

Ports:
clk  in  1  clock
rst  in  1  asynchronous, active-high reset
win_valid  in  1  upstream window+filter valid
win_ready  out  1  sequencer can accept a window
win_data  in  9*IN_WIDTH  element (r,c) at [(3r+c)*IN_WIDTH +: IN_WIDTH]
win_filter  in  9*W_WIDTH  weight (r,c) at [(3r+c)*W_WIDTH +: W_WIDTH]
pe_start  out  1  level start to PE
pe_in_data  out  3*IN_WIDTH  current row of captured window
pe_in_filter  out  3*W_WIDTH  current row of captured filter
pe_in_partial  out  ACC_WIDTH  chained partial sum
pe_out_data  in  ACC_WIDTH  PE result, valid while pe_finished=1
pe_finished  in  1  PE done flag; held until pe_start drops
res_valid  out  1  result valid
res_ready  in  1  downstream accepts result
res_data  out  ACC_WIDTH  final window sum

Behaviour:
- Reset (async): state=S_IDLE, row=0, partial=0, pe_start=0, res_valid=0, res_data=0, win_ready=0 on the reset cycle. Captured window/filter registers are cleared to 0.
- States:
  - S_IDLE: win_ready=1 only if pe_finished=0. A handshake (win_valid&win_ready) captures win_data/win_filter, sets row=0, sets partial=0 (bias, see feature), and moves to S_RUN.
  - S_RUN: pe_start=1. On pe_finished=1: partial<=pe_out_data, pe_start<=0, go to S_REL.
  - S_REL: pe_start=0. Wait for pe_finished=0. If row==2, res_data<=partial, res_valid<=1, go to S_OUT. Otherwise row<=row+1 and go to S_RUN.
  - S_OUT: hold res_valid/res_data stable until res_ready=1. Then res_valid<=0 and go to S_IDLE.
- pe_in_data/pe_in_filter = captured row[row] slice; pe_in_partial = partial register. All are registered and stable for the entire time pe_start=1 and until pe_finished falls.
- pe_start is never reasserted while pe_finished=1 (guard against stale done).
- pe_finished=1 while in S_IDLE or S_OUT is ignored; no state change.
- win_ready=0 in every state except S_IDLE. Only one window is in flight; there is no buffering.
- Result = sum of 9 products + initial partial, truncated to ACC_WIDTH (wraps; no saturation).
- Latency per row: 1 cycle after pe_finished rises, pe_start falls. The next row's start is asserted 1 cycle after pe_finished falls. Window accept to res_valid = 3 PE round trips + 2 cycles.
- Reset mid-operation: pe_start and res_valid drop immediately. The in-flight window is discarded. After reset the sequencer waits in S_IDLE for pe_finished=0 before accepting.
- res_ready asserted while res_valid=0 has no effect.

Optional Feature:
Macro PE_SEQ_BIAS_EN.
- Defined: adds port bias in ACC_WIDTH, captured with the window on the win handshake. Row 0 pe_in_partial = captured bias.
- Undefined: no bias port; row 0 partial = 0.

Test Plan:
- All-ones window, all-ones filter -> res_data=9; exactly 3 pe_start pulses; pe_in_partial sequence 0,3,6.
- win_data elements 1..9 row-major, filter all 2 -> res_data=90; per-row PE outputs 12,42,90.
- All elements 31, all weights 255, ACC_WIDTH=15 -> res_data=5609 (71145 mod 32768).
- res_ready held low 20 cycles after res_valid -> res_valid/res_data stable, win_ready=0 throughout; accept on release, then back-to-back second window accepted.
- rst pulsed mid S_RUN of row 1 -> pe_start=0 same cycle; next window (all ones) yields 9, no residue from the aborted window.
- PE_SEQ_BIAS_EN defined, bias=100, all-ones window/filter -> res_data=109; row 0 pe_in_partial=100.
